// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronised board reset, POR hold, ordered channel release.
// Optional watchdog is enabled by defining RST_SEQ_WDOG_EN.
module rst_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int POR_CYCLES  = 16,
   parameter int STAGE_GAP   = 4,
   parameter int SOFT_HOLD   = 8,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NUM_CH-1:0] soft_rst_i,
   input  logic              wdog_kick_i,
   output logic [NUM_CH-1:0] resetn_o,
   output logic              seq_done_o,
   output logic [1:0]        state_o,
   output logic              wdog_trip_o
);

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_POR  = 2'd1,
      S_REL  = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   localparam int CMAX = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = $clog2(NUM_CH + 1);
   localparam int HW   = $clog2(SOFT_HOLD + 1);

   localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] ALL_CH   = IW'(NUM_CH);
   localparam logic [IW-1:0] ONE_CH   = IW'(1);
   localparam logic [HW-1:0] HOLD_END = HW'(SOFT_HOLD);

   state_t          state_q;
   state_t          state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]   cnt_q;
   logic [IW-1:0]   idx_q;
   logic            sync_clr;
   logic            por_done;
   logic            gap_done;
   logic            all_rel;
   logic            wdog_exp;

   assign sync_clr = ~sync_q[SYNC_STAGES-2];
   assign all_rel  = (idx_q == ALL_CH);
   assign por_done = (state_q == S_POR) && (cnt_q == POR_LAST);
   assign gap_done = (state_q == S_REL) && !all_rel && (cnt_q == GAP_LAST);

   // Deassertion synchroniser: zeros shift in once the board reset falls.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) sync_q <= '1;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_HOLD;
      else         state_q <= state_d;
   end

   // FSM next-state; HOLD leaves on the same edge the synchroniser clears.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_HOLD: if (sync_clr) state_d = S_POR;
         S_POR:  if (por_done) state_d = S_REL;
         S_REL:  if (all_rel)  state_d = S_RUN;
         S_RUN:  if (wdog_exp) state_d = S_POR;
      endcase
   end

   // FSM outputs.
   always_comb begin
      state_o    = state_q;
      seq_done_o = (state_q == S_RUN);
   end

   // Shared POR / stage-gap counter; saturates once every channel is out.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         cnt_q <= '0;
      else if (por_done || gap_done)
         cnt_q <= '0;
      else if (state_q != S_POR && state_q != S_REL)
         cnt_q <= '0;
      else if (!all_rel)
         cnt_q <= cnt_q + 1'b1;
   end

   // Number of channels already released in the current sequence.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)              idx_q <= '0;
      else if (por_done)        idx_q <= ONE_CH;
      else if (gap_done)        idx_q <= idx_q + 1'b1;
      else if (state_q != S_REL) idx_q <= '0;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [IW-1:0] KI  = IW'(k);
      localparam bit            IS0 = (k == 0);

      logic          rn_q;
      logic [HW-1:0] hcnt_q;

      // Channel reset output: ordered release, then soft reset in RUN.
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            rn_q <= 1'b0;
         end else begin
            unique case (state_q)
               S_HOLD: rn_q <= 1'b0;
               S_POR:  rn_q <= por_done && IS0;
               S_REL:  if (gap_done && idx_q == KI) rn_q <= 1'b1;
               S_RUN: begin
                  if (wdog_exp || soft_rst_i[k])
                     rn_q <= 1'b0;
                  else if (!rn_q && hcnt_q == HOLD_END)
                     rn_q <= 1'b1;
               end
            endcase
         end
      end

      // Soft-reset hold counter; a new request restarts it.
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i)
            hcnt_q <= '0;
         else if (state_q != S_RUN || soft_rst_i[k])
            hcnt_q <= '0;
         else if (!rn_q && hcnt_q != HOLD_END)
            hcnt_q <= hcnt_q + 1'b1;
      end

      assign resetn_o[k] = rn_q;
   end

`ifdef RST_SEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

   logic [WW-1:0] wcnt_q;
   logic          trip_q;

   assign wdog_exp = (state_q == S_RUN) && !wdog_kick_i
                   && (wcnt_q == WD_LAST);

   // Watchdog: runs only in RUN, a kick on the expiry cycle wins.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wcnt_q <= '0;
         trip_q <= 1'b0;
      end else begin
         trip_q <= wdog_exp;
         if (state_q != S_RUN || wdog_kick_i || wdog_exp)
            wcnt_q <= '0;
         else
            wcnt_q <= wcnt_q + 1'b1;
      end
   end

   assign wdog_trip_o = trip_q;
`else
   localparam int unused_wdog = WDOG_CYCLES;
   logic unused_kick;

   assign unused_kick = wdog_kick_i;
   assign wdog_exp    = 1'b0;
   assign wdog_trip_o = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: release timing, async abort,
// soft reset holds, small-parameter instance and optional watchdog.
module tb_rst_sequencer;

   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic [3:0] soft_rst = '0;
   logic       kick = 1'b0;
   logic [3:0] resetn;
   logic       done;
   logic [1:0] state;
   logic       trip;

   logic [0:0] soft6 = '0;
   logic [0:0] resetn6;
   logic       done6;
   logic [1:0] state6;
   logic       trip6;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   rst_sequencer #(.WDOG_CYCLES(32)) u_dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .soft_rst_i (soft_rst),
      .wdog_kick_i(kick),
      .resetn_o   (resetn),
      .seq_done_o (done),
      .state_o    (state),
      .wdog_trip_o(trip)
   );

   rst_sequencer #(
      .NUM_CH(1), .STAGE_GAP(1), .POR_CYCLES(1)
   ) u_small (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .soft_rst_i (soft6),
      .wdog_kick_i(1'b0),
      .resetn_o   (resetn6),
      .seq_done_o (done6),
      .state_o    (state6),
      .wdog_trip_o(trip6)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
      cyc += n;
   endtask

   task automatic at(input int n);
      if (n > cyc) tick(n - cyc);
   endtask

   // Hold reset 3 cycles, release, and stop #1 after t0 with cyc = 0.
   task automatic start_seq();
      reset_i = 1'b1;
      tick(3);
      reset_i = 1'b0;
      tick(2);
      cyc = 0;
   endtask

   int c;
   int k_last;
   logic seen;

   initial begin
      #2 reset_i = 1'b1;
      #1;
      chk("rst_resetn", 32'(resetn), 32'h0);
      chk("rst_done",   32'(done),   32'h0);
      chk("rst_state",  32'(state),  32'h0);
      chk("rst_trip",   32'(trip),   32'h0);

      // 1: nominal release sequence, plus the one-channel instance
      start_seq();
      chk("t0_state",  32'(state),   32'h1);
      chk("t0_resetn", 32'(resetn),  32'h0);
      chk("s6_t0",     32'(resetn6), 32'h0);
      at(1);
      chk("s6_rel",    32'(resetn6), 32'h1);
      chk("s6_done0",  32'(done6),   32'h0);
      at(2);
      chk("s6_done",   32'(done6),   32'h1);
      chk("s6_state",  32'(state6),  32'h3);
      at(15);
      chk("por_hold",  32'(resetn),  32'h0);
      chk("por_state", 32'(state),   32'h1);
      at(16);
      chk("rel_ch0",   32'(resetn),  32'h1);
      chk("rel_state", 32'(state),   32'h2);
      at(19);
      chk("rel_gap",   32'(resetn),  32'h1);
      at(20);
      chk("rel_ch1",   32'(resetn),  32'h3);
      at(24);
      chk("rel_ch2",   32'(resetn),  32'h7);
      at(28);
      chk("rel_ch3",   32'(resetn),  32'hF);
      chk("done_early", 32'(done),   32'h0);
      at(29);
      chk("run_done",  32'(done),    32'h1);
      chk("run_state", 32'(state),   32'h3);

      // 2: asynchronous abort mid-sequence, then identical re-run
      reset_i = 1'b0;
      start_seq();
      at(21);
      #2 reset_i = 1'b1;
      #1;
      chk("abort_resetn", 32'(resetn), 32'h0);
      chk("abort_state",  32'(state),  32'h0);
      #2 reset_i = 1'b0;
      tick(2);
      cyc = 0;
      chk("re_t0",   32'(state),  32'h1);
      at(15);
      chk("re_por",  32'(resetn), 32'h0);
      at(16);
      chk("re_ch0",  32'(resetn), 32'h1);
      at(28);
      chk("re_ch3",  32'(resetn), 32'hF);
      at(29);
      chk("re_done", 32'(done),   32'h1);

      // 3: soft reset on channel 2, then a restart inside the hold
      c = cyc;
      soft_rst = 4'b0100;
      tick(1);
      chk("soft_low", 32'(resetn), 32'hB);
      tick(2);
      soft_rst = 4'b0000;
      at(c + 11);
      chk("soft_hold", 32'(resetn), 32'hB);
      chk("soft_done", 32'(done),   32'h1);
      at(c + 12);
      chk("soft_rel",  32'(resetn), 32'hF);

      c = cyc;
      soft_rst = 4'b0100;
      tick(3);
      soft_rst = 4'b0000;
      at(c + 8);
      soft_rst = 4'b0100;
      tick(1);
      soft_rst = 4'b0000;
      at(c + 12);
      chk("rearm_ext",  32'(resetn), 32'hB);
      at(c + 17);
      chk("rearm_hold", 32'(resetn), 32'hB);
      at(c + 18);
      chk("rearm_rel",  32'(resetn), 32'hF);

      // 4: requests during RELEASE are ignored; paired soft reset in RUN
      start_seq();
      at(16);
      chk("ign_ch0", 32'(resetn), 32'h1);
      soft_rst = 4'b1111;
      at(20);
      chk("ign_ch1", 32'(resetn), 32'h3);
      at(24);
      chk("ign_ch2", 32'(resetn), 32'h7);
      at(28);
      chk("ign_ch3", 32'(resetn), 32'hF);
      soft_rst = 4'b0000;
      at(29);
      chk("ign_done", 32'(done), 32'h1);
      c = cyc;
      soft_rst = 4'b0011;
      tick(1);
      soft_rst = 4'b0000;
      chk("pair_low",  32'(resetn), 32'hC);
      at(c + 9);
      chk("pair_hold", 32'(resetn), 32'hC);
      at(c + 10);
      chk("pair_rel",  32'(resetn), 32'hF);

`ifdef RST_SEQ_WDOG_EN
      // 5: regular kicks keep the watchdog quiet; then let it expire
      seen = 1'b0;
      k_last = 0;
      for (int i = 0; i < 4; i++) begin
         kick = 1'b1;
         tick(1);
         kick = 1'b0;
         k_last = cyc;
         seen |= trip;
         for (int j = 0; j < 19; j++) begin
            tick(1);
            seen |= trip;
         end
      end
      chk("wd_quiet", 32'(seen), 32'h0);
      at(k_last + 31);
      chk("wd_pre",    32'(trip),   32'h0);
      chk("wd_pre_st", 32'(state),  32'h3);
      at(k_last + 32);
      chk("wd_trip",   32'(trip),   32'h1);
      chk("wd_resetn", 32'(resetn), 32'h0);
      chk("wd_state",  32'(state),  32'h1);
      at(k_last + 33);
      chk("wd_pulse",  32'(trip),   32'h0);
      at(k_last + 32 + 16);
      chk("wd_ch0",    32'(resetn), 32'h1);
      at(k_last + 32 + 29);
      chk("wd_done",   32'(done),   32'h1);
`else
      tick(40);
      chk("trip_tied", 32'(trip), 32'h0);
      chk("trip_run",  32'(done), 32'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
